// File: rtl/aes_pkg.sv
// Shared AES definitions: word/round-key types, key length encodings,
// Nk/Nr lookup tables, the forward S-box and GF(2^8) helpers.
package aes_pkg;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] round_key_t;

  typedef enum logic [1:0] {
    KEY_128 = 2'd0,
    KEY_192 = 2'd1,
    KEY_256 = 2'd2,
    KEY_BAD = 2'd3
  } key_len_t;

  localparam logic [3:0] NK_LUT [4] = '{4'd4,  4'd6,  4'd8,  4'd0};
  localparam logic [3:0] NR_LUT [4] = '{4'd10, 4'd12, 4'd14, 4'd0};

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  // Multiply by x in GF(2^8), reducing by the AES polynomial on overflow.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic word_t rot_word(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// Combinational AES SubWord: four parallel S-box lookups on a 32-bit word.
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [31:0] data,
  output logic [31:0] subst
);

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    assign subst[8*g +: 8] = sbox(data[8*g +: 8]);
  end

endmodule

// File: rtl/aes_key_schedule_seq.sv
// Sequential AES-128/192/256 key expansion, one schedule word per clock,
// with an internal word store and a registered round-key read port.
module aes_key_schedule_seq
  import aes_pkg::*;
#(
  parameter int unsigned MAX_ROUNDS = 14,
  parameter int unsigned KEY_W      = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       key_len,
  input  logic [KEY_W-1:0] key,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             key_ready,
  output logic [3:0]       nr,
  input  logic             rd_en,
  input  logic [3:0]       rd_round,
  output logic [127:0]     rd_key,
  output logic             rd_valid
);

  localparam int unsigned DEPTH = 4 * (MAX_ROUNDS + 1);
  localparam int unsigned AW    = $clog2(DEPTH);

  typedef enum logic {IDLE, EXPAND} state_t;

  state_t        state;
  word_t         w [DEPTH];
  logic [AW-1:0] idx;
  logic [2:0]    j;
  logic [3:0]    nk_q;
  logic [3:0]    nr_q;
  logic [7:0]    rcon;

  word_t         temp;
  word_t         back;
  word_t         sub_in;
  word_t         sub_out;
  word_t         f;
  word_t         next_w;
  logic [AW-1:0] last_idx;
  logic [AW-1:0] rd_base;
  logic          rd_hit;

  assign temp     = w[idx - AW'(1)];
  assign back     = w[idx - AW'(nk_q)];
  assign last_idx = AW'({nr_q, 2'b11});

  // One shared SubWord serves both the rotated (j==0) and the AES-256 (j==4) cases.
  assign sub_in = (j == 3'd0) ? rot_word(temp) : temp;

  aes_sub_word u_sub_word (
    .data  (sub_in),
    .subst (sub_out)
  );

  always_comb begin
    f = temp;
    if (j == 3'd0)
      f = sub_out ^ {rcon, 24'h0};
    else if (nk_q == 4'd8 && j == 3'd4)
      f = sub_out;
  end

  assign next_w = back ^ f;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      key_ready <= 1'b0;
      nr        <= '0;
      idx       <= '0;
      j         <= '0;
      nk_q      <= '0;
      nr_q      <= '0;
      rcon      <= '0;
      for (int unsigned n = 0; n < DEPTH; n++) w[n] <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (key_len_t'(key_len) == KEY_BAD) begin
              err <= 1'b1;
            end else begin
              for (int unsigned n = 0; n < 8; n++)
                if (n < 32'(NK_LUT[key_len])) w[n] <= key[KEY_W-1-32*n -: 32];
              nk_q      <= NK_LUT[key_len];
              nr_q      <= NR_LUT[key_len];
              idx       <= AW'(NK_LUT[key_len]);
              j         <= '0;
              rcon      <= 8'h01;
              key_ready <= 1'b0;
              busy      <= 1'b1;
              state     <= EXPAND;
            end
          end
        end
        EXPAND: begin
          w[idx] <= next_w;
          idx    <= idx + AW'(1);
          if (j == 3'(nk_q - 4'd1)) j <= '0;
          else                      j <= j + 3'd1;
          if (j == 3'd0) rcon <= xtime(rcon);
          if (idx == last_idx) begin
            busy      <= 1'b0;
            done      <= 1'b1;
            key_ready <= 1'b1;
            nr        <= nr_q;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rd_base = AW'({rd_round, 2'b00});
  // Bound against MAX_ROUNDS as well so the 4-word mux never indexes past the store.
  assign rd_hit  = key_ready && (rd_round <= nr) && (32'(rd_round) <= MAX_ROUNDS);

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_key   <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en)
        rd_key <= rd_hit ? {w[rd_base], w[rd_base + AW'(1)],
                            w[rd_base + AW'(2)], w[rd_base + AW'(3)]} : '0;
    end
  end

endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// Self-checking bench: random and known-answer keys checked against a FIPS-197
// key expansion model with an S-box derived from GF(2^8) inversion.
module tb_aes_key_schedule_seq;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   key_len;
  logic [255:0] key;
  logic         busy;
  logic         done;
  logic         err;
  logic         key_ready;
  logic [3:0]   nr;
  logic         rd_en;
  logic [3:0]   rd_round;
  logic [127:0] rd_key;
  logic         rd_valid;

  int checks = 0;
  int errors = 0;

  logic [7:0]  msbox [256];
  logic [31:0] mw [60];
  int          m_nr;
  int          m_nk;
  logic [7:0]  rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  aes_key_schedule_seq #(.MAX_ROUNDS(14), .KEY_W(256)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .key_len   (key_len),
    .key       (key),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .key_ready (key_ready),
    .nr        (nr),
    .rd_en     (rd_en),
    .rd_round  (rd_round),
    .rd_key    (rd_key),
    .rd_valid  (rd_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = '0;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d = {x, x};
    return d[15-n -: 8];
  endfunction

  task automatic build_sbox;
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv = '0;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      msbox[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] m_subw(input logic [31:0] t);
    return {msbox[t[31:24]], msbox[t[23:16]], msbox[t[15:8]], msbox[t[7:0]]};
  endfunction

  task automatic model_expand(input logic [1:0] kl, input logic [255:0] k);
    logic [31:0] t;
    m_nk = 4 + 2 * int'(kl);
    m_nr = m_nk + 6;
    for (int i = 0; i < 60; i++) mw[i] = '0;
    for (int i = 0; i < m_nk; i++) mw[i] = k[255-32*i -: 32];
    for (int i = m_nk; i < 4 * (m_nr + 1); i++) begin
      t = mw[i-1];
      if (i % m_nk == 0)
        t = m_subw({t[23:0], t[31:24]}) ^ {rcon_tab[i/m_nk - 1], 24'h0};
      else if (m_nk > 6 && i % m_nk == 4)
        t = m_subw(t);
      mw[i] = mw[i-m_nk] ^ t;
    end
  endtask

  function automatic logic [127:0] m_rk(input int r);
    return {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
  endfunction

  // Start an expansion and time it; optionally pulse a second start mid-run.
  task automatic expand(input logic [1:0] kl, input logic [255:0] k, input int glitch_at, input string tag);
    int cyc = 0;
    int busy_cnt = 0;
    int err_cnt = 0;
    int lat;
    model_expand(kl, k);
    lat = 4 * (m_nr + 1) - m_nk;
    start = 1'b1; key_len = kl; key = k;
    tick();
    start = 1'b0;
    check({tag, " key_ready cleared"}, 128'(key_ready), 128'(0));
    while (!done && cyc < 200) begin
      if (busy) busy_cnt++;
      if (err) err_cnt++;
      if (cyc == glitch_at && glitch_at > 0) begin
        start = 1'b1; key_len = 2'd2; key = ~k;
      end
      tick();
      start = 1'b0;
      cyc++;
    end
    check({tag, " latency"}, 128'(cyc), 128'(lat));
    check({tag, " busy cycles"}, 128'(busy_cnt), 128'(lat));
    check({tag, " no err"}, 128'(err_cnt), 128'(0));
    check({tag, " done"}, 128'(done), 128'(1));
    check({tag, " key_ready"}, 128'(key_ready), 128'(1));
    check({tag, " nr"}, 128'(nr), 128'(m_nr));
    tick();
    check({tag, " done one cycle"}, 128'(done), 128'(0));
    check({tag, " idle"}, 128'(busy), 128'(0));
  endtask

  task automatic read_check(input int r, input logic [127:0] exp, input string tag);
    rd_en = 1'b1; rd_round = 4'(r);
    tick();
    rd_en = 1'b0;
    check({tag, " rd_valid"}, 128'(rd_valid), 128'(1));
    check(tag, rd_key, exp);
  endtask

  task automatic read_all(input string tag);
    for (int r = 0; r <= m_nr; r++)
      read_check(r, m_rk(r), $sformatf("%s round %0d", tag, r));
    read_check(m_nr + 1, 128'(0), $sformatf("%s round %0d out of range", tag, m_nr + 1));
  endtask

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  initial begin
    logic [255:0] rk;
    reset = 1'b1; start = 1'b0; key_len = '0; key = '0; rd_en = 1'b0; rd_round = '0;
    build_sbox();
    repeat (3) tick();
    check("reset busy", 128'(busy), 128'(0));
    check("reset done", 128'(done), 128'(0));
    check("reset err", 128'(err), 128'(0));
    check("reset key_ready", 128'(key_ready), 128'(0));
    check("reset nr", 128'(nr), 128'(0));
    check("reset rd_valid", 128'(rd_valid), 128'(0));
    check("reset rd_key", rd_key, 128'(0));
    reset = 1'b0;
    tick();

    // AES-128 known answer, then back-to-back reads of all rounds
    expand(2'd0, K128, 0, "aes128");
    read_check(10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "aes128 kat round 10");
    read_check(0, 128'h2b7e151628aed2a6abf7158809cf4f3c, "aes128 kat round 0");
    rd_en = 1'b1;
    for (int r = 0; r <= 10; r++) begin
      rd_round = 4'(r);
      tick();
      check($sformatf("b2b round %0d rd_valid", r), 128'(rd_valid), 128'(1));
      check($sformatf("b2b round %0d", r), rd_key, m_rk(r));
    end
    rd_en = 1'b0;
    tick();
    check("b2b rd_valid drop", 128'(rd_valid), 128'(0));
    read_check(11, 128'(0), "aes128 round 11");

    expand(2'd1, K192, 0, "aes192");
    read_check(12, 128'he98ba06f448c773c8ecc720401002202, "aes192 kat round 12");

    expand(2'd2, K256, 0, "aes256");
    read_check(14, 128'hfe4890d1e6188d0b046df344706c631e, "aes256 kat round 14");
    read_check(15, 128'(0), "aes256 round 15");

    // Illegal key length leaves the held schedule alone
    start = 1'b1; key_len = 2'd3; key = ~K256;
    tick();
    start = 1'b0;
    check("illegal err", 128'(err), 128'(1));
    check("illegal busy", 128'(busy), 128'(0));
    check("illegal key_ready", 128'(key_ready), 128'(1));
    check("illegal nr", 128'(nr), 128'(14));
    tick();
    check("illegal err pulse", 128'(err), 128'(0));
    read_check(14, 128'hfe4890d1e6188d0b046df344706c631e, "illegal kept round 14");

    // Start mid-expansion is ignored
    expand(2'd0, K128, 10, "glitch128");
    read_all("glitch128");

    // Reset part-way through an AES-256 expansion
    start = 1'b1; key_len = 2'd2; key = K256;
    tick();
    start = 1'b0;
    repeat (19) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midreset busy", 128'(busy), 128'(0));
    check("midreset done", 128'(done), 128'(0));
    check("midreset key_ready", 128'(key_ready), 128'(0));
    check("midreset nr", 128'(nr), 128'(0));
    check("midreset rd_valid", 128'(rd_valid), 128'(0));
    check("midreset rd_key", rd_key, 128'(0));
    tick();
    check("midreset no done", 128'(done), 128'(0));
    read_check(0, 128'(0), "midreset round 0");
    expand(2'd0, K128, 0, "after reset");
    read_all("after reset");

    // Random keys with junk in the unused low bits
    for (int n = 0; n < 6; n++) begin
      for (int b = 0; b < 8; b++) rk[32*b +: 32] = $urandom();
      expand(2'(n % 3), rk, (n == 4) ? int'($urandom_range(1, 30)) : 0, $sformatf("rand%0d", n));
      read_all($sformatf("rand%0d", n));
      begin
        int r = int'($urandom_range(0, 15));
        read_check(r, (r <= m_nr) ? m_rk(r) : 128'(0), $sformatf("rand%0d pick %0d", n, r));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_key_schedule_seq.md
# aes_key_schedule_seq

Sequential, parametrised AES key schedule supporting AES-128, AES-192 and AES-256 selected at run time. It generates one 32-bit schedule word per clock and stores the full round-key set internally. Any round key can then be read back through a registered read port. It replaces the fixed-width, fully combinational 256-bit expansion: the multi-cipher datapath loads a key once and then fetches round keys by index, at much lower area.

## Interface
Parameters:
- MAX_ROUNDS, 14: deepest supported round count; storage is 4*(MAX_ROUNDS+1) words.
- KEY_W, 256: key input width; shorter keys are left-aligned (MSB first).

Ports:
- clk, input, 1: single clock, rising edge.
- reset, input, 1: synchronous, active-high.
- start, input, 1: single-cycle request to expand `key`. Sampled only when idle.
- key_len, input, 2: key size select. 0 = 128 (Nk=4, Nr=10), 1 = 192 (Nk=6, Nr=12), 2 = 256 (Nk=8, Nr=14), 3 = illegal.
- key, input, KEY_W: cipher key. Bits [255:256-32*Nk] are used; the rest are ignored.
- busy, output, 1: expansion in progress.
- done, output, 1: one-cycle pulse when the last word is written.
- err, output, 1: one-cycle pulse when start is seen with key_len=3.
- key_ready, output, 1: a complete schedule is held; cleared by start or reset.
- nr, output, 4: Nr of the held schedule (10/12/14); 0 after reset.
- rd_en, input, 1: read request.
- rd_round, input, 4: round index 0..Nr.
- rd_key, output, 128: round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}.
- rd_valid, output, 1: rd_key valid; asserted the cycle after rd_en.

## Operation
- States: IDLE and EXPAND.
- IDLE:
  - start with key_len=3: err=1, no other change.
  - start with legal key_len: on the same edge, load w[0..Nk-1] from key, latch Nk/Nr, set i=Nk, j=0 (i mod Nk), rcon=0x01, key_ready=0, busy=1. Go to EXPAND.
- EXPAND: each cycle compute temp=w[i-1] and write w[i]=w[i-Nk]^f(temp):
  - j==0: f = SubWord(RotWord(temp)) ^ {rcon,24'h0}; afterwards rcon = xtime(rcon), reduced by 0x1B on overflow.
  - Nk==8 and j==4: f = SubWord(temp).
  - otherwise: f = temp.
  - Then increment i and increment j with wrap at Nk.
- Final word is i = 4*Nr+3 (43/51/59). On that write: busy=0, done=1, key_ready=1, nr=Nr. Go to IDLE.
- start while busy is ignored; no err, no restart.
- Read port is independent of state:
  - rd_key = stored round key if rd_round ≤ nr and key_ready=1; otherwise 0.
  - A read issued while busy returns 0.
- Words beyond 4*Nr+3 are never written and keep stale or zero content. They are not reachable because of the rd_round ≤ nr check.
- Reset:
  - Outputs: busy=0, done=0, err=0, key_ready=0, nr=0, rd_valid=0, rd_key=0.
  - State returns to IDLE. Word storage is cleared to 0.
  - Reset mid-expansion abandons the schedule; no done pulse.

## Timing
- start-to-done latency equals the number of generated words: 40 (128), 46 (192), 52 (256) cycles after the start edge. busy is high for exactly those cycles.
- done and key_ready rise on the same edge; done lasts one cycle.
- Read latency is 1 cycle: rd_en at edge E gives rd_key/rd_valid after E. Back-to-back reads give one key per cycle.
- A start on the cycle after done is accepted.
- Critical path: one SubWord (4 S-boxes) plus two XORs, per cycle.

## Structure
- Shared package aes_pkg holds:
  - S-box constant/function.
  - xtime function.
  - key_len encodings and Nk/Nr lookup constants.
  - word and round-key typedefs.
- Sub-module aes_sub_word: 32-bit combinational, four S-box instances. Reused by the cipher datapath.
- Storage is a flat register array of 4*(MAX_ROUNDS+1) 32-bit words. Indexed write; 4-word read mux.

## Test plan
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, start -> done after 40 cycles; round 10 reads d014f9a8c9ee2589e13f0cc8b6630ca6; round 0 reads the key; nr=10.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> done after 46 cycles; round 12 = e98ba06f448c773c8ecc720401002202.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> done after 52 cycles; round 14 = fe4890d1e6188d0b046df344706c631e; rd_round=15 returns 0.
- start with key_len=3 -> err pulse, busy stays 0, prior key_ready/schedule unchanged. start pulsed mid-expansion -> ignored, result identical to the first run.
- reset at cycle 20 of an AES-256 expansion -> all outputs 0 next cycle; a read of round 0 returns 0; a following AES-128 run completes correctly.
- Back-to-back reads of rounds 0..10 after AES-128 -> rd_valid high 11 consecutive cycles with FIPS-197 Appendix A.1 values in order.
